// File: rtl/ssd_pkg.sv
// Shared seven-segment display definitions: word format, banner constants
// and the arbiter state encoding.
package ssd_pkg;

  localparam int SSD_W       = 9;
  localparam int SSD_NEG_BIT = 8;

  localparam logic [SSD_W-1:0] SSD_INIT_NR   = 9'h110;
  localparam logic [SSD_W-1:0] SSD_INIT_CD   = 9'h111;
  localparam logic [SSD_W-1:0] SSD_IDLE_CODE = SSD_INIT_NR;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    DONE
  } arb_state_t;

endpackage

// File: rtl/ssd_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [PW-1:0]   off;
  logic [PW:0]     sum;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[PW-1:0];
    end
    valid = |rot;
    sum   = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Shares the 2-digit seven-segment display between NREQ requesters using a
// round-robin grant; each winner's captured word is shown for HOLD_CYCLES.
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int               NREQ        = 3,
  parameter int               HOLD_CYCLES = 100000000,
  parameter logic [SSD_W-1:0] IDLE_CODE   = SSD_IDLE_CODE
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SSD_W-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [SSD_W-1:0]      data_out,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  arb_state_t        state, state_n;
  logic [NREQ-1:0]   grant_n, done_n;
  logic [SSD_W-1:0]  data_n;
  logic              busy_n;
  logic [PW-1:0]     ptr, ptr_n, owner, owner_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [SSD_W-1:0]  words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[SSD_W*g +: SSD_W];
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  function automatic logic [PW-1:0] after(input logic [PW-1:0] k);
    return (k == PTR_LAST) ? '0 : k + 1'b1;
  endfunction

  // Abandon is tested before terminal count so a dropped request never gets a done pulse.
  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    data_n  = data_out;
    busy_n  = busy;
    ptr_n   = ptr;
    cnt_n   = cnt;
    owner_n = owner;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = SHOW;
          grant_n = ONE << pick_idx;
          busy_n  = 1'b1;
          cnt_n   = '0;
          data_n  = words[pick_idx];
          owner_n = pick_idx;
        end else begin
          data_n = IDLE_CODE;
        end
      end
      SHOW: begin
        if (!req[owner]) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = after(owner);
        end else if (cnt == CNT_LAST) begin
          state_n = DONE;
          done_n  = ONE << owner;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = after(owner);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      data_out <= IDLE_CODE;
      busy     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
      owner    <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      done     <= done_n;
      data_out <= data_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      owner    <= owner_n;
    end
  end

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench: two arbiters (HOLD_CYCLES=4 and 1) compared every cycle
// against a behavioural model, plus directed literal expectations.
module tb_ssd_display_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [2:0]  req0 = '0, req1 = '0;
  logic [26:0] dat0 = '0, dat1 = '0;
  logic [2:0]  g0, d0, g1, d1;
  logic [8:0]  o0, o1;
  logic        b0, b1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ssd_display_arbiter #(.NREQ(3), .HOLD_CYCLES(4), .IDLE_CODE(9'h110)) dut0 (
    .clk(clk), .nrst(nrst), .req(req0), .req_data(dat0),
    .grant(g0), .done(d0), .data_out(o0), .busy(b0)
  );

  ssd_display_arbiter #(.NREQ(3), .HOLD_CYCLES(1), .IDLE_CODE(9'h110)) dut1 (
    .clk(clk), .nrst(nrst), .req(req1), .req_data(dat1),
    .grant(g1), .done(d1), .data_out(o1), .busy(b1)
  );

  // Behavioural model: phase 0 = nothing shown, 1 = showing owner, 2 = owner's done cycle.
  typedef struct {
    int         phase;
    int         owner;
    int         shown;
    int         ptr;
    logic [8:0] word;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdlStep(mdl_t m, logic rst_n, logic [2:0] r, logic [26:0] d, int hold);
    mdl_t n;
    bit   found;
    int   k;
    n = m;
    if (!rst_n) begin
      n.phase = 0; n.owner = 0; n.shown = 0; n.ptr = 0; n.word = 9'h110;
      return n;
    end
    if (m.phase == 0) begin
      found  = 1'b0;
      n.word = 9'h110;
      for (int s = 0; s < 3; s++) begin
        k = (m.ptr + s) % 3;
        if (!found && r[k]) begin
          found   = 1'b1;
          n.phase = 1;
          n.owner = k;
          n.shown = 1;
          n.word  = d[9*k +: 9];
        end
      end
    end else if (m.phase == 1) begin
      if (!r[m.owner]) begin
        n.phase = 0;
        n.ptr   = (m.owner + 1) % 3;
      end else if (m.shown == hold) begin
        n.phase = 2;
        n.ptr   = (m.owner + 1) % 3;
      end else begin
        n.shown = m.shown + 1;
      end
    end else begin
      n.phase = 0;
    end
    return n;
  endfunction

  function automatic logic [2:0] mGrant(mdl_t m);
    return (m.phase == 1) ? 3'(1 << m.owner) : 3'b000;
  endfunction

  function automatic logic [2:0] mDone(mdl_t m);
    return (m.phase == 2) ? 3'(1 << m.owner) : 3'b000;
  endfunction

  always @(posedge clk) begin
    m0 = mdlStep(m0, nrst, req0, dat0, 4);
    m1 = mdlStep(m1, nrst, req1, dat1, 1);
  end

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_grant0", {6'b0, g0}, {6'b0, mGrant(m0)});
      checkOutput("model_done0",  {6'b0, d0}, {6'b0, mDone(m0)});
      checkOutput("model_busy0",  {8'b0, b0}, {8'b0, (m0.phase == 1)});
      checkOutput("model_data0",  o0, m0.word);
      checkOutput("model_grant1", {6'b0, g1}, {6'b0, mGrant(m1)});
      checkOutput("model_done1",  {6'b0, d1}, {6'b0, mDone(m1)});
      checkOutput("model_busy1",  {8'b0, b1}, {8'b0, (m1.phase == 1)});
      checkOutput("model_data1",  o1, m1.word);
    end
  end

  // Drive one cycle of inputs on the falling edge and return on the next falling edge.
  task automatic applyStimulus(input logic [2:0] r0, input logic [26:0] w0,
                               input logic [2:0] r1, input logic [26:0] w1, input logic rst_n);
    req0 = r0; dat0 = w0; req1 = r1; dat1 = w1; nrst = rst_n;
    @(negedge clk);
  endtask

  localparam logic [26:0] WORDS_A = {9'h1C4, 9'h0A5, 9'h003};
  localparam logic [26:0] WORDS_B = {9'h07E, 9'h111, 9'h042};

  logic [2:0]  exp_g1 [7] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001};
  logic [2:0]  exp_d1 [7] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
  logic [2:0]  exp_fair [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    logic [2:0]  r, rr, last;
    logic [2:0]  order [4];
    int          ng;
    logic [26:0] w;
    logic        rn;

    m0 = '{phase: 0, owner: 0, shown: 0, ptr: 0, word: 9'h110};
    m1 = m0;

    // Reset with every request raised.
    applyStimulus(3'b111, WORDS_A, 3'b011, WORDS_B, 1'b0);
    chk_on = 1'b1;
    applyStimulus(3'b111, WORDS_A, 3'b011, WORDS_B, 1'b0);
    checkOutput("rst_grant", {6'b0, g0}, 9'h000);
    checkOutput("rst_done",  {6'b0, d0}, 9'h000);
    checkOutput("rst_busy",  {8'b0, b0}, 9'h000);
    checkOutput("rst_data",  o0, 9'h110);
    applyStimulus(3'b111, WORDS_A, 3'b011, WORDS_B, 1'b1);
    checkOutput("release_grant0", {6'b0, g0}, 9'h001);

    // HOLD_CYCLES=1 with req=011 held: 3-cycle period alternating grants.
    for (int i = 0; i < 7; i++) begin
      checkOutput("hold1_grant", {6'b0, g1}, {6'b0, exp_g1[i]});
      checkOutput("hold1_done",  {6'b0, d1}, {6'b0, exp_d1[i]});
      if (i < 6) applyStimulus(3'b111, WORDS_A, 3'b011, WORDS_B, 1'b1);
    end

    // Single request shown for 4 cycles, then done, then idle code.
    applyStimulus(3'b000, WORDS_A, 3'b000, WORDS_B, 1'b0);
    applyStimulus(3'b010, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("single_data", o0, 9'h0A5);
    for (int i = 0; i < 4; i++) begin
      checkOutput("single_grant", {6'b0, g0}, 9'h002);
      applyStimulus(3'b010, WORDS_A, 3'b000, WORDS_B, 1'b1);
    end
    checkOutput("single_done",  {6'b0, d0}, 9'h002);
    checkOutput("single_ngrant", {6'b0, g0}, 9'h000);
    applyStimulus(3'b000, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("single_hold_word", o0, 9'h0A5);
    applyStimulus(3'b000, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("single_idle_word", o0, 9'h110);

    // Fairness: all requesting, each drops on its done; requester 0 re-raises.
    applyStimulus(3'b000, WORDS_A, 3'b000, WORDS_B, 1'b0);
    r = 3'b111; ng = 0; last = 3'b000;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      applyStimulus(r, WORDS_A, 3'b000, WORDS_B, 1'b1);
      if (g0 != 3'b000 && g0 != last) begin
        order[ng] = g0;
        ng++;
      end
      last = g0;
      if (d0 != 3'b000) begin
        r = r & ~d0;
        if (d0 == 3'b100) r[0] = 1'b1;
      end
    end
    checkOutput("fair_count", 9'(ng), 9'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) checkOutput("fair_order", {6'b0, order[i]}, {6'b0, exp_fair[i]});
    end

    // Abandon: requester 2 drops on its second SHOW cycle; pending 0 follows.
    applyStimulus(3'b000, WORDS_A, 3'b000, WORDS_B, 1'b0);
    applyStimulus(3'b100, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("abandon_grant2", {6'b0, g0}, 9'h004);
    applyStimulus(3'b101, WORDS_A, 3'b000, WORDS_B, 1'b1);
    applyStimulus(3'b001, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("abandon_grant", {6'b0, g0}, 9'h000);
    checkOutput("abandon_done",  {6'b0, d0}, 9'h000);
    applyStimulus(3'b001, WORDS_A, 3'b000, WORDS_B, 1'b1);
    checkOutput("abandon_next", {6'b0, g0}, 9'h001);
    checkOutput("capture_word", o0, 9'h003);

    // Capture: word0 changes mid-SHOW, then reset mid-SHOW.
    applyStimulus(3'b001, {WORDS_A[26:9], 9'h1FF}, 3'b000, WORDS_B, 1'b1);
    checkOutput("capture_hold", o0, 9'h003);
    applyStimulus(3'b001, {WORDS_A[26:9], 9'h1FF}, 3'b000, WORDS_B, 1'b0);
    checkOutput("midrst_data",  o0, 9'h110);
    checkOutput("midrst_done",  {6'b0, d0}, 9'h000);
    checkOutput("midrst_grant", {6'b0, g0}, 9'h000);

    // Randomized traffic on both arbiters, occasional resets.
    r = 3'b000; rr = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
      end
      if ($urandom_range(0, 3) == 0) r = r & ~d0;
      w  = 27'($urandom);
      rn = ($urandom_range(0, 149) != 0);
      applyStimulus(r, w, rr, 27'($urandom), rn);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
